// File: rtl/cordic_feeder.sv
// Front-end feeder for a CORDIC core: pre-rotates (x, y, z) into +/-90 deg and
// hands one sample at a time downstream. Define CORDIC_FEEDER_FIFO_EN for a 2-entry input FIFO.
module cordic_feeder #(
    parameter int unsigned N_FRAC = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [N_FRAC:0]   x_i,
    input  logic signed [N_FRAC:0]   y_i,
    input  logic signed [N_FRAC:0]   z_i,
    input  logic                     data_in_valid_strobe_i,
    input  logic                     cordic_done_strobe_i,
    output logic signed [N_FRAC:0]   x_o,
    output logic signed [N_FRAC:0]   y_o,
    output logic signed [N_FRAC:0]   z_o,
    output logic                     data_out_valid_strobe_o,
    output logic                     busy_o,
    output logic                     overflow_o
);

    localparam int unsigned W = N_FRAC + 1;
    localparam logic signed [W-1:0] Q_S     = W'(2 ** (N_FRAC - 1));
    localparam logic signed [W-1:0] NEG_Q_S = -Q_S;
    localparam logic signed [W-1:0] MIN_S   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_S   = {1'b0, {(W-1){1'b1}}};

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] z;
    } sample_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t  state_q, state_d;
    sample_t out_q, out_d;
    sample_t in_c, src_c;
    logic    valid_q, busy_q, ovf_q;
    logic    drop_c, issue_c;

`ifdef CORDIC_FEEDER_FIFO_EN
    sample_t    fifo_q [2];
    sample_t    fifo_d [2];
    logic [1:0] cnt_q, cnt_d;
    logic       push_c, pop_c;
`endif

    // Negating the most negative code would wrap, so clamp it to the top code.
    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        return (v == MIN_S) ? MAX_S : -v;
    endfunction

    // Fold the angle into [-90, 90] deg by an exact quarter-turn of the vector.
    function automatic sample_t prerot(input sample_t s);
        sample_t r;
        r = s;
        if (s.z > Q_S) begin
            r.x = neg_sat(s.y);
            r.y = s.x;
            r.z = s.z - Q_S;
        end else if (s.z < NEG_Q_S) begin
            r.x = s.y;
            r.y = neg_sat(s.x);
            r.z = s.z + Q_S;
        end
        return r;
    endfunction

    assign in_c = {x_i, y_i, z_i};

    // Next-state and issue/drop decisions.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        drop_c  = 1'b0;
        issue_c = 1'b0;
        src_c   = in_c;
`ifdef CORDIC_FEEDER_FIFO_EN
        push_c  = 1'b0;
        pop_c   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef CORDIC_FEEDER_FIFO_EN
                if (cnt_q != 2'd0) begin
                    pop_c   = 1'b1;
                    issue_c = 1'b1;
                    src_c   = fifo_q[0];
                    push_c  = data_in_valid_strobe_i;
                end else if (data_in_valid_strobe_i) begin
                    issue_c = 1'b1;
                end
`else
                if (data_in_valid_strobe_i) begin
                    issue_c = 1'b1;
                end
`endif
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (cordic_done_strobe_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && data_in_valid_strobe_i) begin
`ifdef CORDIC_FEEDER_FIFO_EN
            if (cnt_q == 2'd2) drop_c = 1'b1;
            else               push_c = 1'b1;
`else
            drop_c = 1'b1;
`endif
        end

        if (issue_c) begin
            out_d   = prerot(src_c);
            state_d = ISSUE;
        end
    end

`ifdef CORDIC_FEEDER_FIFO_EN
    // Oldest entry lives in slot 0; a pop shifts before the push lands.
    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        if (pop_c) begin
            fifo_d[0] = fifo_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (push_c) begin
            if (cnt_d == 2'd0) fifo_d[0] = in_c;
            else               fifo_d[1] = in_c;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fifo_q <= fifo_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= (state_d == ISSUE);
            busy_q  <= (state_d != IDLE);
            ovf_q   <= drop_c;
        end
    end

    assign x_o                     = out_q.x;
    assign y_o                     = out_q.y;
    assign z_o                     = out_q.z;
    assign data_out_valid_strobe_o = valid_q;
    assign busy_o                  = busy_q;
    assign overflow_o              = ovf_q;

endmodule

// File: tb/tb_cordic_feeder.sv
// Directed plus random bench for cordic_feeder against a queue-based reference model.
module tb_cordic_feeder;

    localparam int unsigned N_FRAC = 7;
    localparam int unsigned W      = N_FRAC + 1;
`ifdef CORDIC_FEEDER_FIFO_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 0;
`endif

    logic clk = 1'b0;
    logic rst_i, strobe, done;
    logic signed [W-1:0] x_i, y_i, z_i;
    logic signed [W-1:0] x_o, y_o, z_o;
    logic valid_o, busy_o, ovf_o;

    always #5 clk = ~clk;

    cordic_feeder #(.N_FRAC(N_FRAC)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .x_i                    (x_i),
        .y_i                    (y_i),
        .z_i                    (z_i),
        .data_in_valid_strobe_i (strobe),
        .cordic_done_strobe_i   (done),
        .x_o                    (x_o),
        .y_o                    (y_o),
        .z_o                    (z_o),
        .data_out_valid_strobe_o(valid_o),
        .busy_o                 (busy_o),
        .overflow_o             (ovf_o)
    );

    typedef struct {
        int x;
        int y;
        int z;
    } samp_t;

    int    total = 0;
    int    bad   = 0;
    samp_t q[$];
    int    ex, ey, ez;
    bit    ev, eb, eo, m_out;

    function automatic int neg_sat(input int v);
        return (-v > 127) ? 127 : -v;
    endfunction

    function automatic samp_t prerot(input samp_t s);
        samp_t r;
        r = s;
        if (s.z > 64) begin
            r.x = neg_sat(s.y); r.y = s.x; r.z = s.z - 64;
        end else if (s.z < -64) begin
            r.x = s.y; r.y = neg_sat(s.x); r.z = s.z + 64;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock of the reference: outstanding flag plus a bounded sample queue.
    task automatic model(input bit s, input samp_t in, input bit d, input bit r);
        samp_t src;
        bit    iss;
        iss = 1'b0;
        src = in;
        if (r) begin
            q.delete();
            ex = 0; ey = 0; ez = 0;
            ev = 0; eb = 0; eo = 0; m_out = 0;
            return;
        end
        eo = 0;
        if (!m_out) begin
            if (q.size() > 0) begin
                src = q.pop_front();
                iss = 1'b1;
                if (s) q.push_back(in);
            end else if (s) begin
                iss = 1'b1;
            end
        end else begin
            if (s) begin
                if (q.size() < DEPTH) q.push_back(in);
                else                  eo = 1;
            end
            if (!ev && d) m_out = 0;
        end
        if (iss) begin
            src = prerot(src);
            ex = src.x; ey = src.y; ez = src.z;
            m_out = 1;
        end
        ev = iss;
        eb = m_out;
    endtask

    task automatic cyc(input bit s, input int x, input int y, input int z, input bit d, input bit r);
        samp_t in;
        in.x = x; in.y = y; in.z = z;
        @(negedge clk);
        strobe = s; done = d; rst_i = r;
        x_i = W'(x); y_i = W'(y); z_i = W'(z);
        model(s, in, d, r);
        @(posedge clk);
        #1;
        chk("valid", int'(valid_o), int'(ev));
        chk("busy",  int'(busy_o),  int'(eb));
        chk("ovf",   int'(ovf_o),   int'(eo));
        chk("x_o",   int'(x_o),     ex);
        chk("y_o",   int'(y_o),     ey);
        chk("z_o",   int'(z_o),     ez);
    endtask

    function automatic int rnd_val();
        case ($urandom % 10)
            0:       return -128;
            1:       return 127;
            2:       return 64;
            3:       return -64;
            4:       return 65;
            5:       return -65;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    initial begin
        strobe = 0; done = 0; rst_i = 1;
        x_i = '0; y_i = '0; z_i = '0;

        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_x", int'(x_o), 0);
        chk("rst_valid", int'(valid_o), 0);

        // Basic pass-through issue
        cyc(1, 100, 0, 32, 0, 0);
        chk("r27_valid", int'(valid_o), 1);
        chk("r27_x", int'(x_o), 100);
        chk("r27_y", int'(y_o), 0);
        chk("r27_z", int'(z_o), 32);
        chk("r27_busy", int'(busy_o), 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r27_hold_valid", int'(valid_o), 0);
        chk("r27_hold_x", int'(x_o), 100);
        cyc(0, 0, 0, 0, 1, 0);
        chk("r27_idle_busy", int'(busy_o), 0);

        // Rotations and saturation
        cyc(1, 50, 20, 100, 0, 0);
        chk("r28a_x", int'(x_o), -20);
        chk("r28a_y", int'(y_o), 50);
        chk("r28a_z", int'(z_o), 36);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 50, 20, -100, 0, 0);
        chk("r28b_x", int'(x_o), 20);
        chk("r28b_y", int'(y_o), -50);
        chk("r28b_z", int'(z_o), -36);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, -128, 10, -128, 0, 0);
        chk("r29_x", int'(x_o), 10);
        chk("r29_y", int'(y_o), 127);
        chk("r29_z", int'(z_o), -64);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);

`ifndef CORDIC_FEEDER_FIFO_EN
        // Drop during WAIT, then normal accept
        cyc(1, 1, 2, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 5, 6, 7, 0, 0);
        chk("r30_ovf", int'(ovf_o), 1);
        chk("r30_novalid", int'(valid_o), 0);
        chk("r30_hold_z", int'(z_o), 3);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r30_ovf_clr", int'(ovf_o), 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("r30_busy", int'(busy_o), 0);
        cyc(1, 9, 9, 9, 0, 0);
        chk("r30_valid", int'(valid_o), 1);
        chk("r30_z", int'(z_o), 9);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
`else
        // Queue two, drop the third, drain in order
        cyc(1, 0, 0, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 10, 0, 0);
        cyc(1, 0, 0, 20, 0, 0);
        chk("r31_ovf0", int'(ovf_o), 0);
        cyc(1, 0, 0, 30, 0, 0);
        chk("r31_ovf", int'(ovf_o), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("r31_gap_valid", int'(valid_o), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r31_valid1", int'(valid_o), 1);
        chk("r31_z1", int'(z_o), 10);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r31_valid2", int'(valid_o), 1);
        chk("r31_z2", int'(z_o), 20);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r31_empty", int'(valid_o), 0);
`endif

        // Reset in WAIT with pending samples, strobe coincident with reset
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 2, 2, 2, 0, 0);
        cyc(1, 3, 3, 3, 0, 0);
        cyc(1, 4, 4, 4, 0, 1);
        chk("r32_x", int'(x_o), 0);
        chk("r32_busy", int'(busy_o), 0);
        chk("r32_valid", int'(valid_o), 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("r32_after_valid", int'(valid_o), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit s, d, r;
            s = ($urandom % 100) < 40;
            d = ($urandom % 100) < 30;
            r = ($urandom % 100) < 2;
            cyc(s, rnd_val(), rnd_val(), rnd_val(), d, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_feeder.md
CORDIC_FEEDER -- requirements
Module: cordic_feeder

Interface
REQ-001 SHALL have parameter N_FRAC, default 7; data width is N_FRAC+1 bits, signed two's complement.
REQ-002 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have x_i, y_i, z_i  input  N_FRAC+1 each  signed input vector and angle; z full scale 2^N_FRAC counts = 180 deg.
REQ-005 SHALL have data_in_valid_strobe_i  input  1  one-cycle pulse qualifying x_i/y_i/z_i.
REQ-006 SHALL have cordic_done_strobe_i  input  1  downstream CORDIC finished-pulse; connects to the CORDIC data_out_valid_strobe_o.
REQ-007 SHALL have x_o, y_o, z_o  output  N_FRAC+1 each  registered pre-rotated vector and angle for the downstream CORDIC.
REQ-008 SHALL have data_out_valid_strobe_o  output  1  one-cycle pulse qualifying x_o/y_o/z_o; drives the CORDIC input strobe.
REQ-009 SHALL have busy_o  output  1  high while a sample is issued and its CORDIC result is outstanding.
REQ-010 SHALL have overflow_o  output  1  one-cycle pulse when an input sample is dropped.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT; busy_o = (state != IDLE).
REQ-012 IDLE: on an accepted sample, SHALL register its pre-rotated values into x_o/y_o/z_o and go to ISSUE; data_out_valid_strobe_o is high exactly in ISSUE.
REQ-013 ISSUE SHALL last one cycle, then go to WAIT unconditionally.
REQ-014 WAIT: cordic_done_strobe_i SHALL cause a transition to IDLE on the next edge; done strobes in IDLE or ISSUE SHALL be ignored.
REQ-015 Latency SHALL be one cycle: strobe at edge n while IDLE with no queued data -> data_out_valid_strobe_o high in cycle n+1.
REQ-016 Pre-rotation with Q = 2^(N_FRAC-1) (90 deg): z > Q -> x'=-y, y'=x, z'=z-Q; z < -Q -> x'=y, y'=-x, z'=z+Q; otherwise pass through unchanged.
REQ-017 Negation of the most negative value (-2^N_FRAC) SHALL saturate to 2^N_FRAC-1; z arithmetic SHALL not overflow (result lies within [-Q, Q]).
REQ-018 x_o/y_o/z_o SHALL hold their last issued values between strobes.
REQ-019 A sample arriving while busy_o is high, including the WAIT cycle that sees cordic_done_strobe_i, SHALL be dropped or queued per REQ-025/REQ-026.
REQ-020 A dropped sample SHALL pulse overflow_o in the cycle after the dropped strobe; state and outputs SHALL be unaffected.

Reset
REQ-021 With rst_i high at an edge, x_o, y_o, z_o SHALL be 0, data_out_valid_strobe_o 0, overflow_o 0, busy_o 0, and state IDLE.
REQ-022 Reset mid-operation (ISSUE/WAIT) SHALL abandon the outstanding transaction and discard any queued samples.
REQ-023 A data_in_valid_strobe_i coincident with rst_i high SHALL be ignored.

Configuration
REQ-024 Macro CORDIC_FEEDER_FIFO_EN SHALL select input buffering.
REQ-025 Without CORDIC_FEEDER_FIFO_EN: no storage beyond output registers; every sample arriving while busy_o is high SHALL be dropped with overflow_o.
REQ-026 With CORDIC_FEEDER_FIFO_EN: a 2-entry FIFO of raw samples.
- Samples arriving while busy, or while IDLE with the FIFO non-empty, SHALL be pushed.
- IDLE with the FIFO non-empty SHALL pop the oldest entry, pre-rotate it and go to ISSUE.
- A push when full SHALL drop the sample with overflow_o; a simultaneous push and pop when full SHALL succeed.
- Order SHALL be preserved.

Verification
REQ-027 x=100, y=0, z=32 strobe in IDLE -> next cycle strobe high, x_o=100, y_o=0, z_o=32, busy_o=1.
REQ-028 x=50, y=20, z=100 -> x_o=-20, y_o=50, z_o=36; x=50, y=20, z=-100 -> x_o=20, y_o=-50, z_o=-36.
REQ-029 x=-128, y=10, z=-128 -> x_o=10, y_o=127 (saturated), z_o=-64.
REQ-030 FIFO off: second strobe during WAIT -> overflow_o pulse, no output strobe; done strobe -> busy_o=0 one cycle later; next strobe accepted normally.
REQ-031 FIFO on: three strobes (z=10, 20, 30) during WAIT -> third pulses overflow_o; successive done strobes -> z_o=10 then 20, each issued 2 cycles after its done strobe.
REQ-032 rst_i high for one cycle in WAIT with two queued samples -> outputs 0, busy_o=0, later done strobes produce no output strobe.
